// File: rtl/l1_denorm_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : l1_denorm_stream                                           |
// | Description : Multiplies a frame of VEC_LEN normalized fixed-point       |
// |               elements by that frame's L1 norm. The result is rounded    |
// |               half-up and saturated. Valid/ready on all streams, with a  |
// |               2-stage multiply/round pipeline.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module l1_denorm_stream #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 16,
  parameter int VEC_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              norm_valid,
  output logic              norm_ready,
  input  logic [DATA_W-1:0] norm_data,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] input_data,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] output_data,
  output logic              last_out,
  output logic              busy,
  output logic              err_sat
);

  localparam int PROD_W = 2*DATA_W + 1;
  localparam logic [15:0] LAST_IDX = 16'(VEC_LEN - 1);
  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (FRAC_W - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX  = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN  = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [DATA_W-1:0] norm_q, norm_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              elem_last;

  logic                     s1_valid_q;
  logic                     s1_last_q;
  logic signed [PROD_W-1:0] s1_prod_q;

  logic              valid_out_q;
  logic              last_out_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic en;
  logic elem_acc;
  logic norm_acc;
  logic out_last_hs;

  logic signed [PROD_W-1:0] w_x_ext;
  logic signed [PROD_W-1:0] w_n_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_sum;
  logic signed [PROD_W-1:0] w_shr;
  logic                     w_sat_hi;
  logic                     w_sat_lo;
  logic [DATA_W-1:0]        w_res;

  // The whole pipeline moves only when the output register is free or being drained.
  assign en          = !valid_out_q || ready_out;
  assign elem_acc    = valid_in && ready_in;
  assign norm_acc    = norm_valid && norm_ready;
  assign out_last_hs = valid_out_q && ready_out && last_out_q;

  // Stage-1 operands: element sign-extended, norm zero-extended (it is unsigned).
  assign w_x_ext = {{(DATA_W+1){input_data[DATA_W-1]}}, input_data};
  assign w_n_ext = {{(DATA_W+1){1'b0}}, norm_q};
  assign w_prod  = w_x_ext * w_n_ext;

  // Stage-2 round half-up toward +inf, then clamp into the signed DATA_W range.
  always_comb begin
    w_sum    = s1_prod_q + RND_HALF;
    w_shr    = w_sum >>> FRAC_W;
    w_sat_hi = (w_shr > SAT_MAX);
    w_sat_lo = (w_shr < SAT_MIN);
    if (w_sat_hi)      w_res = SAT_MAX[DATA_W-1:0];
    else if (w_sat_lo) w_res = SAT_MIN[DATA_W-1:0];
    else               w_res = w_shr[DATA_W-1:0];
  end

  // Frame sequencing: take a norm, count VEC_LEN elements, wait for the last output.
  always_comb begin
    state_d    = state_q;
    norm_d     = norm_q;
    cnt_d      = cnt_q;
    elem_last  = 1'b0;
    norm_ready = 1'b0;
    ready_in   = 1'b0;
    case (state_q)
      S_IDLE: begin
        norm_ready = 1'b1;
        if (norm_valid) begin
          norm_d  = norm_data;
          cnt_d   = 16'd0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        ready_in = en;
        if (valid_in && en) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_IDX) begin
            elem_last = 1'b1;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_last_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      norm_q  <= '0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      norm_q  <= norm_d;
      cnt_q   <= cnt_d;
    end
  end

  // Two-stage datapath; bubbles travel as valid=0 and every stage holds on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_prod_q   <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      data_q      <= '0;
    end else if (en) begin
      s1_valid_q  <= elem_acc;
      s1_last_q   <= elem_last;
      s1_prod_q   <= w_prod;
      valid_out_q <= s1_valid_q;
      last_out_q  <= s1_last_q;
      data_q      <= w_res;
    end
  end

  // Sticky saturation flag, cleared when a new frame's norm is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (norm_acc) begin
      err_q <= 1'b0;
    end else if (en && s1_valid_q && (w_sat_hi || w_sat_lo)) begin
      err_q <= 1'b1;
    end
  end

  assign valid_out   = valid_out_q;
  assign last_out    = last_out_q;
  assign output_data = data_q;
  assign err_sat     = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_l1_denorm_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_l1_denorm_stream                                        |
// | Description : Scoreboard bench for l1_denorm_stream; randomized and      |
// |               directed frames checked against an arithmetic model.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_l1_denorm_stream;

  localparam int DATA_W  = 32;
  localparam int FRAC_W  = 16;
  localparam int VEC_LEN = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              norm_valid = 1'b0;
  logic              norm_ready;
  logic [DATA_W-1:0] norm_data = '0;
  logic              valid_in = 1'b0;
  logic              ready_in;
  logic [DATA_W-1:0] input_data = '0;
  logic              valid_out;
  logic              ready_out = 1'b1;
  logic [DATA_W-1:0] output_data;
  logic              last_out;
  logic              busy;
  logic              err_sat;

  always #5 clk = ~clk;

  l1_denorm_stream #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .VEC_LEN(VEC_LEN)) dut (
    .clk(clk), .rst(rst),
    .norm_valid(norm_valid), .norm_ready(norm_ready), .norm_data(norm_data),
    .valid_in(valid_in), .ready_in(ready_in), .input_data(input_data),
    .valid_out(valid_out), .ready_out(ready_out), .output_data(output_data),
    .last_out(last_out), .busy(busy), .err_sat(err_sat)
  );

  typedef struct { logic [31:0] data; logic last; } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  bit   in_frame = 0;
  int   sent     = 0;
  int   n_out    = 0;
  bit   exp_err  = 0;
  bit   lat_chk  = 0;
  int   first_acc_cyc = -1;
  int   first_out_cyc = -1;
  int   last_hs_cyc   = -100;
  int   rmode    = 0;
  logic [31:0] cur_norm;
  logic [31:0] xs[VEC_LEN];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic abort(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    summary_and_finish();
  endtask

  // Reference: exact product, +0.5 LSB, floor division by 2^FRAC_W, clamp.
  function automatic logic [31:0] ref_denorm(input logic [31:0] x, input logic [31:0] n,
                                             output bit sat);
    longint p, q;
    p = longint'($signed(x)) * longint'(n);
    p = p + 64'sd32768;
    q = p / 64'sd65536;
    if (p < 0 && q * 64'sd65536 != p) q = q - 1;
    sat = 0;
    if (q > 64'sd2147483647) begin
      q = 64'sd2147483647; sat = 1;
    end else if (q < -64'sd2147483648) begin
      q = -64'sd2147483648; sat = 1;
    end
    return q[31:0];
  endfunction

  // Downstream ready patterns: steady, fixed toggle sequence, random, held low.
  initial begin : ready_gen
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    int pi = 0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: ready_out = 1'b1;
        1: begin ready_out = pat[pi]; pi = (pi + 1) % 6; end
        2: ready_out = 1'($urandom_range(1));
        default: ready_out = 1'b0;
      endcase
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on every output handshake.
  initial begin : monitor
    exp_t        e;
    bit          stalled = 0;
    logic [31:0] stall_data;
    logic        stall_last;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        check("norm_ready", norm_ready, !in_frame);
        check("busy", busy, in_frame);
        check("ready_in", ready_in, in_frame && sent < VEC_LEN && (!valid_out || ready_out));
        if (stalled) begin
          check("stall_valid", valid_out, 1'b1);
          check("stall_data", output_data, stall_data);
          check("stall_last", last_out, stall_last);
        end
        stalled    = valid_out && !ready_out;
        stall_data = output_data;
        stall_last = last_out;
        if (valid_out && ready_out) begin
          n_out++;
          if (first_out_cyc < 0) begin
            first_out_cyc = cyc;
            if (lat_chk) check("latency", first_out_cyc - first_acc_cyc, 2);
          end
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h, expected no output", output_data);
          end else begin
            e = sb.pop_front();
            check("out_data", output_data, e.data);
            check("out_last", last_out, e.last);
            if (e.last) begin
              check("frame_count", n_out, VEC_LEN);
              check("err_sat_frame", err_sat, exp_err);
              in_frame    = 0;
              last_hs_cyc = cyc;
            end
          end
        end
      end
    end
  end

  task automatic send_norm(input logic [31:0] n, input bit chk_b2b);
    int t = 0;
    int acc_cyc;
    valid_in   = 1'b0;
    norm_valid = 1'b1;
    norm_data  = n;
    forever begin
      @(negedge clk);
      if (norm_ready) break;
      t++;
      if (t > 500) abort("norm_accept_timeout");
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    norm_valid    = 1'b0;
    in_frame      = 1;
    sent          = 0;
    n_out         = 0;
    exp_err       = 0;
    cur_norm      = n;
    first_acc_cyc = -1;
    first_out_cyc = -1;
    check("err_clear_on_norm", err_sat, 1'b0);
    if (chk_b2b) check("b2b_norm_cycle", acc_cyc, last_hs_cyc + 1);
  endtask

  task automatic send_elems(input int count, input int gap_pct, input bit hold_norm);
    int t;
    bit s;
    exp_t e;
    for (int i = 0; i < count; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        valid_in   = 1'b0;
        input_data = $urandom;
        if (hold_norm) begin norm_valid = 1'b1; norm_data = $urandom; end
        @(posedge clk); #1;
      end
      valid_in   = 1'b1;
      input_data = xs[i];
      if (hold_norm) begin norm_valid = 1'b1; norm_data = $urandom; end
      t = 0;
      forever begin
        @(negedge clk);
        if (ready_in) break;
        t++;
        if (t > 500) abort("elem_accept_timeout");
      end
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      e.data = ref_denorm(xs[i], cur_norm, s);
      e.last = (i == VEC_LEN - 1);
      if (s) exp_err = 1;
      sb.push_back(e);
      @(posedge clk); #1;
      sent++;
    end
    valid_in   = 1'b0;
    norm_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (in_frame) begin
      @(negedge clk);
      t++;
      if (t > 2000) abort("drain_timeout");
    end
    @(posedge clk); #1;
  endtask

  task automatic fill(input logic [31:0] x);
    for (int i = 0; i < VEC_LEN; i++) xs[i] = x;
  endtask

  task automatic fill_random(input bit wide);
    for (int i = 0; i < VEC_LEN; i++) begin
      if (wide && $urandom_range(3) == 0) xs[i] = $urandom;
      else xs[i] = 32'($urandom_range(131072)) - 32'd65536;
    end
  endtask

  // Garbage on the element port while idle must be ignored.
  task automatic idle_junk(input int k);
    for (int i = 0; i < k; i++) begin
      valid_in   = 1'b1;
      input_data = $urandom;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    abort("global_timeout");
  end

  initial begin : driver
    logic [31:0] nrm;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_last_out", last_out, 1'b0);
    check("rst_output_data", output_data, 32'h0);
    check("rst_err_sat", err_sat, 1'b0);
    @(posedge clk); #1;

    // Basic frame: 4.0 * 0.25 everywhere, steady ready, no gaps.
    rmode = 0;
    lat_chk = 1;
    send_norm(32'h0004_0000, 0);
    fill(32'h0000_4000);
    send_elems(VEC_LEN, 0, 0);
    wait_done();
    lat_chk = 0;

    // Sign and rounding cases, chained back to back.
    send_norm(32'h0003_0000, 0);
    fill(32'hFFFF_8000);
    send_elems(VEC_LEN, 0, 1);
    send_norm(32'h0000_0001, 1);
    fill(32'h0000_8000);
    send_elems(VEC_LEN, 0, 0);
    send_norm(32'h0000_0001, 1);
    fill(32'hFFFF_8000);
    send_elems(VEC_LEN, 0, 0);
    wait_done();

    // Saturation, then a zero norm whose accept must clear the flag.
    send_norm(32'h7FFF_FFFF, 0);
    fill(32'h0002_0000);
    send_elems(VEC_LEN, 0, 0);
    wait_done();
    send_norm(32'h0000_0000, 0);
    fill_random(1);
    send_elems(VEC_LEN, 0, 0);
    wait_done();

    // Backpressure with the fixed ready pattern and valid_in held high.
    rmode = 1;
    send_norm(32'h0002_8000, 0);
    fill_random(0);
    send_elems(VEC_LEN, 0, 1);
    wait_done();

    // Randomized frames with gaps, random ready and idle garbage.
    rmode = 2;
    for (int f = 0; f < 8; f++) begin
      idle_junk(int'($urandom_range(3)));
      nrm = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(32'h0010_0000));
      send_norm(nrm, 0);
      fill_random(1);
      send_elems(VEC_LEN, 30, f[0]);
      if (f[1]) wait_done();
    end
    wait_done();

    // Reset mid-frame with outputs in flight and err_sat set.
    rmode = 0;
    send_norm(32'h7FFF_FFFF, 0);
    fill(32'h0002_0000);
    send_elems(3, 0, 0);
    check("err_before_rst", err_sat, exp_err);
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    sb.delete();
    in_frame = 0;
    sent     = 0;
    @(negedge clk);
    check("midrst_valid_out", valid_out, 1'b0);
    check("midrst_err_sat", err_sat, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_norm_ready", norm_ready, 1'b1);
    @(posedge clk); #1;

    // A full frame after the reset must come out intact.
    send_norm(32'h0001_8000, 0);
    fill_random(1);
    send_elems(VEC_LEN, 10, 0);
    wait_done();

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    summary_and_finish();
  end

endmodule
`default_nettype wire
